// File: rtl/conv_stream_driver_if.sv
// Valid/ready bundle between conv_stream_driver (master) and the convolution
// block (slave): x and f flow outbound, y flows back.
interface conv_stream_driver_if #(
  parameter int WIDTH  = 8,
  parameter int OWIDTH = 18
);
  logic signed [WIDTH-1:0]  m_data_out_x;
  logic                     m_valid_x;
  logic                     m_ready_x;
  logic signed [WIDTH-1:0]  m_data_out_f;
  logic                     m_valid_f;
  logic                     m_ready_f;
  logic signed [OWIDTH-1:0] s_data_in_y;
  logic                     s_valid_y;
  logic                     s_ready_y;

  modport master (
    output m_data_out_x, m_valid_x,
    input  m_ready_x,
    output m_data_out_f, m_valid_f,
    input  m_ready_f,
    input  s_data_in_y, s_valid_y,
    output s_ready_y
  );

  modport slave (
    input  m_data_out_x, m_valid_x,
    output m_ready_x,
    input  m_data_out_f, m_valid_f,
    output m_ready_f,
    output s_data_in_y, s_valid_y,
    input  s_ready_y
  );
endinterface

// File: rtl/conv_stream_driver.sv
// Streams a stored x vector and filter f into conv_8_4 over independent
// valid/ready channels, then buffers the returned y words for readback.
module conv_stream_driver #(
  parameter int XLEN   = 8,
  parameter int FLEN   = 4,
  parameter int WIDTH  = 8,
  parameter int OWIDTH = 18,
  parameter int YLEN   = XLEN - FLEN + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [2:0]               wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  conv_stream_driver_if.master     strm,
  input  logic [2:0]               rd_addr,
  output logic signed [OWIDTH-1:0] rd_data
);
  localparam int XCW = $clog2(XLEN + 1);
  localparam int FCW = $clog2(FLEN + 1);
  localparam int YCW = $clog2(YLEN + 1);
  localparam int XIW = $clog2(XLEN);
  localparam int FIW = $clog2(FLEN);
  localparam logic [XCW-1:0] X_END  = XCW'(XLEN);
  localparam logic [FCW-1:0] F_END  = FCW'(FLEN);
  localparam logic [YCW-1:0] Y_END  = YCW'(YLEN);
  localparam logic [2:0]     RD_END = 3'(YLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                   state;
  logic [XCW-1:0]           xc, xc_nxt;
  logic [FCW-1:0]           fc, fc_nxt;
  logic [YCW-1:0]           yc, yc_nxt;
  logic                     x_fire, f_fire, y_fire, all_done;
  logic signed [WIDTH-1:0]  x_mem [XLEN];
  logic signed [WIDTH-1:0]  f_mem [FLEN];
  logic signed [OWIDTH-1:0] y_mem [YLEN];

  always_comb begin
    strm.m_valid_x = (state == RUN) && (xc < X_END);
    strm.m_valid_f = (state == RUN) && (fc < F_END);
    strm.s_ready_y = (state == RUN) && (yc < Y_END);
    // Exhausted counters point past the store, so drive zero rather than wrap.
    strm.m_data_out_x = (xc < X_END) ? x_mem[xc[XIW-1:0]] : '0;
    strm.m_data_out_f = (fc < F_END) ? f_mem[fc[FIW-1:0]] : '0;

    x_fire = strm.m_valid_x && strm.m_ready_x;
    f_fire = strm.m_valid_f && strm.m_ready_f;
    y_fire = strm.s_valid_y && strm.s_ready_y;
    xc_nxt = xc + XCW'(x_fire);
    fc_nxt = fc + FCW'(f_fire);
    yc_nxt = yc + YCW'(y_fire);
    all_done = (xc_nxt == X_END) && (fc_nxt == F_END) && (yc_nxt == Y_END);

    busy = (state == RUN);
    done = (state == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      xc      <= '0;
      fc      <= '0;
      yc      <= '0;
      rd_data <= '0;
      // NOTE: the stores are reset on purpose so a reset mid-run streams and reads zeros.
      for (int i = 0; i < XLEN; i++) x_mem[i] <= '0;
      for (int i = 0; i < FLEN; i++) f_mem[i] <= '0;
      for (int i = 0; i < YLEN; i++) y_mem[i] <= '0;
    end else begin
      // Reads see the pre-edge buffer, so a same-edge capture returns the old word.
      rd_data <= (rd_addr < RD_END) ? y_mem[rd_addr] : '0;

      if (wr_en && state != RUN) begin
        if (wr_sel) f_mem[wr_addr[FIW-1:0]] <= wr_data;
        else        x_mem[wr_addr[XIW-1:0]] <= wr_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            xc    <= '0;
            fc    <= '0;
            yc    <= '0;
          end
        end
        RUN: begin
          xc <= xc_nxt;
          fc <= fc_nxt;
          yc <= yc_nxt;
          if (y_fire) y_mem[yc] <= strm.s_data_in_y;
          if (all_done) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver: nominal run, backpressure, early and
// excess y, extreme values, ignored inputs in RUN and reset mid-run.
module tb_conv_stream_driver;
  localparam int XLEN   = 8;
  localparam int FLEN   = 4;
  localparam int WIDTH  = 8;
  localparam int OWIDTH = 18;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wr_en, wr_sel, start;
  logic [2:0]               wr_addr, rd_addr;
  logic signed [WIDTH-1:0]  wr_data;
  logic                     busy, done;
  logic signed [OWIDTH-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_beat_cyc = 0;
  logic [WIDTH-1:0] xq[$];
  logic [WIDTH-1:0] fq[$];

  conv_stream_driver_if #(.WIDTH(WIDTH), .OWIDTH(OWIDTH)) sif ();

  conv_stream_driver #(
    .XLEN(XLEN), .FLEN(FLEN), .WIDTH(WIDTH), .OWIDTH(OWIDTH)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .busy(busy), .done(done), .strm(sif.master),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beats are logged mid-cycle, when both sides of each handshake are settled.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sif.m_valid_x && sif.m_ready_x) begin xq.push_back(sif.m_data_out_x); last_beat_cyc = cyc; end
      if (sif.m_valid_f && sif.m_ready_f) begin fq.push_back(sif.m_data_out_f); last_beat_cyc = cyc; end
      if (sif.s_valid_y && sif.s_ready_y) last_beat_cyc = cyc;
    end
  end

  function automatic logic [4:0] status();
    return {busy, done, sif.m_valid_x, sif.m_valid_f, sif.s_ready_y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_elem(input logic sel, input int addr, input int val);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = WIDTH'(val);
    step();
    wr_en = 1'b0;
  endtask

  // All readies high, five y words base+i*stp in the first five RUN cycles;
  // optionally pokes wr_en/start during RUN. Returns the RUN-relative done cycle.
  task automatic run_full(input int ybase, input int stp, input bit inject, output int done_at);
    done_at = -1;
    sif.m_ready_x = 1'b1; sif.m_ready_f = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin done_at = i; break; end
      sif.s_valid_y   = (i < 5);
      sif.s_data_in_y = OWIDTH'(ybase + i * stp);
      wr_en = inject && (i == 1); start = inject && (i == 1);
      wr_sel = 1'b0; wr_addr = 3'd2; wr_data = 8'sd55;
      step();
    end
    sif.s_valid_y = 1'b0; wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; start = 0; rd_addr = 0;
    sif.m_ready_x = 0; sif.m_ready_f = 0; sif.s_valid_y = 0; sif.s_data_in_y = '0;
    #12;
    n_checks++; if (status() !== 5'b0) begin n_fail++; $display("FAIL reset_status: got %b want 00000", status()); end
    n_checks++; if (sif.m_data_out_x !== 8'h00) begin n_fail++; $display("FAIL reset_data_x: got %h want 00", sif.m_data_out_x); end
    n_checks++; if (sif.m_data_out_f !== 8'h00) begin n_fail++; $display("FAIL reset_data_f: got %h want 00", sif.m_data_out_f); end
    n_checks++; if (rd_data !== 18'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    @(negedge clk); reset = 1'b0;
    sif.m_ready_x = 1; sif.m_ready_f = 1;
    step(); step();
    n_checks++; if (status() !== 5'b0) begin n_fail++; $display("FAIL idle_status: got %b want 00000", status()); end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < XLEN; i++) write_elem(1'b0, i, i + 1);
    for (int i = 0; i < FLEN; i++) write_elem(1'b1, i, 1);
    xq.delete(); fq.delete();
    sif.m_ready_x = 1; sif.m_ready_f = 1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (status() !== {3'b101, i < 4, i < 5}) begin
        n_fail++; $display("FAIL nominal_status c%0d: got %b want %b", i + 1, status(), {3'b101, i < 4, i < 5});
      end
      n_checks++;
      if (sif.m_data_out_x !== 8'(i + 1)) begin
        n_fail++; $display("FAIL nominal_x c%0d: got %h want %h", i + 1, sif.m_data_out_x, 8'(i + 1));
      end
      if (i < 4) begin
        n_checks++;
        if (sif.m_data_out_f !== 8'h01) begin n_fail++; $display("FAIL nominal_f c%0d: got %h want 01", i + 1, sif.m_data_out_f); end
      end
      sif.s_valid_y = (i < 5); sif.s_data_in_y = OWIDTH'(10 + 4 * i);
      step();
    end
    sif.s_valid_y = 1'b0;
    n_checks++; if (status() !== 5'b01000) begin n_fail++; $display("FAIL nominal_done: got %b want 01000", status()); end
    step();
    n_checks++; if (status() !== 5'b00000) begin n_fail++; $display("FAIL nominal_idle: got %b want 00000", status()); end
    for (int k = 0; k < 5; k++) begin
      rd_addr = 3'(k); step();
      n_checks++;
      if (rd_data !== OWIDTH'(10 + 4 * k)) begin n_fail++; $display("FAIL nominal_rd%0d: got %0d want %0d", k, rd_data, 10 + 4 * k); end
    end
    n_checks++; if (xq.size() != 8 || fq.size() != 4) begin n_fail++; $display("FAIL nominal_beats: got x=%0d f=%0d want 8/4", xq.size(), fq.size()); end
  endtask

  task automatic test_backpressure();
    int done_at = -1;
    int done_cyc = 0;
    for (int i = 0; i < XLEN; i++) write_elem(1'b0, i, 8'h30 + i);
    for (int i = 0; i < FLEN; i++) write_elem(1'b1, i, -(i + 1));
    xq.delete(); fq.delete();
    sif.m_ready_x = 1; sif.m_ready_f = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin done_at = i; done_cyc = cyc; break; end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (sif.m_data_out_x !== 8'h31) begin n_fail++; $display("FAIL bp_hold c%0d: got %h want 31", i, sif.m_data_out_x); end
      end
      sif.m_ready_x = (i % 2 == 0);
      sif.m_ready_f = (i >= 3);
      sif.s_valid_y = (i < 5); sif.s_data_in_y = OWIDTH'(200 + i);
      step();
    end
    sif.s_valid_y = 1'b0; sif.m_ready_x = 1; sif.m_ready_f = 1;
    step();
    n_checks++; if (done_at != 15) begin n_fail++; $display("FAIL bp_done_at: got %0d want 15", done_at); end
    n_checks++; if (done_cyc != last_beat_cyc + 1) begin n_fail++; $display("FAIL bp_done_after_last: got %0d want %0d", done_cyc, last_beat_cyc + 1); end
    n_checks++; if (xq.size() != 8 || fq.size() != 4) begin n_fail++; $display("FAIL bp_beats: got x=%0d f=%0d want 8/4", xq.size(), fq.size()); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (xq[k] !== 8'(8'h30 + k)) begin n_fail++; $display("FAIL bp_x%0d: got %h want %h", k, xq[k], 8'(8'h30 + k)); end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (fq[k] !== 8'(-(k + 1))) begin n_fail++; $display("FAIL bp_f%0d: got %h want %h", k, fq[k], 8'(-(k + 1))); end
    end
  endtask

  task automatic test_early_y();
    int done_at = -1;
    sif.m_ready_x = 0; sif.m_ready_f = 1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin done_at = i; break; end
      if (i == 5) begin
        n_checks++;
        if ({busy, sif.s_ready_y} !== 2'b10) begin n_fail++; $display("FAIL early_ready_low: got %b want 10", {busy, sif.s_ready_y}); end
      end
      sif.m_ready_x = (i >= 6);
      sif.s_valid_y = 1'b1;
      sif.s_data_in_y = (i < 5) ? OWIDTH'(100 + i) : OWIDTH'(99);
      step();
    end
    sif.s_valid_y = 1'b0; sif.m_ready_x = 1;
    step();
    n_checks++; if (done_at != 14) begin n_fail++; $display("FAIL early_done_at: got %0d want 14", done_at); end
    for (int k = 0; k < 6; k++) begin
      rd_addr = 3'(k); step();
      n_checks++;
      if (rd_data !== ((k < 5) ? OWIDTH'(100 + k) : OWIDTH'(0))) begin
        n_fail++; $display("FAIL early_rd%0d: got %0d want %0d", k, rd_data, (k < 5) ? 100 + k : 0);
      end
    end
  endtask

  task automatic test_extremes();
    int done_at;
    write_elem(1'b0, 0, -128);
    write_elem(1'b1, 3, 127);
    xq.delete(); fq.delete();
    run_full(-131072, 0, 1'b0, done_at);
    step();
    n_checks++; if (xq[0] !== 8'h80) begin n_fail++; $display("FAIL ext_x0: got %h want 80", xq[0]); end
    n_checks++; if (fq[3] !== 8'h7f) begin n_fail++; $display("FAIL ext_f3: got %h want 7f", fq[3]); end
    rd_addr = 3'd0; step();
    n_checks++; if (rd_data !== 18'h20000) begin n_fail++; $display("FAIL ext_rd0: got %h want 20000", rd_data); end
  endtask

  task automatic test_ignored();
    int done_at;
    xq.delete();
    run_full(0, 1, 1'b1, done_at);
    n_checks++; if (done_at != 8) begin n_fail++; $display("FAIL ign_done_at: got %0d want 8", done_at); end
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (status() !== 5'b00000) begin n_fail++; $display("FAIL ign_fin_start: got %b want 00000", status()); end
    step();
    n_checks++; if (status() !== 5'b00000) begin n_fail++; $display("FAIL ign_idle: got %b want 00000", status()); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (xq[k] !== ((k == 0) ? 8'h80 : 8'(8'h30 + k))) begin
        n_fail++; $display("FAIL ign_x%0d: got %h want %h", k, xq[k], (k == 0) ? 8'h80 : 8'(8'h30 + k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_at;
    sif.m_ready_x = 1; sif.m_ready_f = 1; sif.s_valid_y = 0;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (status() !== 5'b0) begin n_fail++; $display("FAIL rst_mid_status: got %b want 00000", status()); end
    n_checks++; if (rd_data !== 18'h0 || sif.m_data_out_x !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_data: got rd=%h x=%h want 0/00", rd_data, sif.m_data_out_x);
    end
    #1 reset = 1'b0;
    step();
    for (int i = 0; i < XLEN; i++) write_elem(1'b0, i, 21 + i);
    for (int i = 0; i < FLEN; i++) write_elem(1'b1, i, 5 + i);
    xq.delete(); fq.delete();
    run_full(0, 1, 1'b0, done_at);
    step();
    n_checks++; if (done_at != 8) begin n_fail++; $display("FAIL rst_rerun_done_at: got %0d want 8", done_at); end
    n_checks++; if (xq.size() != 8 || xq[0] !== 8'd21 || xq[7] !== 8'd28) begin
      n_fail++; $display("FAIL rst_rerun_x: got n=%0d first=%0d last=%0d want 8/21/28", xq.size(), xq[0], xq[7]);
    end
    n_checks++; if (fq.size() != 4 || fq[0] !== 8'd5) begin n_fail++; $display("FAIL rst_rerun_f: got n=%0d first=%0d want 4/5", fq.size(), fq[0]); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_y();
    test_extremes();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
